// File: rtl/uart_rx_os.sv
// uart_rx_os: oversampling UART receiver with a configurable frame format.
// The serial input passes through a 2-flop synchroniser. Each bit value is a
// 2-of-3 majority of samples taken around the middle of the bit. The block
// detects framing, parity, overrun and break conditions, and hands each word
// downstream over a valid/ready interface.
module uart_rx_os #(
    parameter int CLK_FREQ   = 25_000_000,
    parameter int BAUD_RATE  = 9600,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    output logic                 break_det,
    output logic                 busy,
    output logic [2:0]           dbg_state
);

    localparam int DIV   = (CLK_FREQ + BAUD_RATE * OVERSAMPLE / 2) / (BAUD_RATE * OVERSAMPLE);
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SC_W  = $clog2(OVERSAMPLE);

    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV - 1);
    localparam logic [SC_W-1:0]  SC_S1    = SC_W'(OVERSAMPLE / 2 - 1);
    localparam logic [SC_W-1:0]  SC_S2    = SC_W'(OVERSAMPLE / 2);
    localparam logic [SC_W-1:0]  SC_DEC   = SC_W'(OVERSAMPLE / 2 + 1);
    localparam logic [SC_W-1:0]  SC_LAST  = SC_W'(OVERSAMPLE - 1);
    localparam logic [3:0]       DB_LAST  = 4'(DATA_BITS - 1);
    localparam logic [3:0]       SB_LAST  = 4'(STOP_BITS - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_PAR   = 3'd3;
    localparam logic [2:0] S_STOP  = 3'd4;

    generate
        if (DIV < 2) begin : g_bad_div
            $error("uart_rx_os: CLK_FREQ too low for BAUD_RATE*OVERSAMPLE (DIV < 2)");
        end
    endgenerate

    logic [1:0]           sync_q, sync_fill_q;
    logic                 rxs;
    logic                 armed_q, armed_d;
    logic [CNT_W-1:0]     tick_cnt_q, tick_cnt_d;
    logic                 tick;
    logic [2:0]           state_q, state_d;
    logic [SC_W-1:0]      sc_q, sc_d;
    logic [3:0]           bit_q, bit_d;
    logic                 s1_q, s1_d, s2_q, s2_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 pend_fe_q, pend_fe_d, pend_pe_q, pend_pe_d;
    logic                 all_zero_q, all_zero_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 frame_err_q, frame_err_d, parity_err_q, parity_err_d;
    logic                 overrun_q, overrun_d, break_q, break_d;
    logic                 maj, at_dec, at_end, par_req, fe_now, zero_now, complete;

    assign rxs  = sync_q[1];
    assign tick = (tick_cnt_q == DIV_LAST);

    // Two-flop synchroniser. sync_fill_q records that real pin samples have
    // reached rxs, so the reset value of the flops cannot arm the receiver.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q      <= 2'b11;
            sync_fill_q <= 2'b00;
        end else begin
            sync_q      <= {sync_q[0], rxd};
            sync_fill_q <= {sync_fill_q[0], 1'b1};
        end
    end

    // Next-state logic: tick divider, bit sampling FSM, frame completion and
    // the output handshake.
    // Handshake: a word transfers on any clock edge where rx_valid and rx_ready
    // are both high. While rx_valid is high and the word has not transferred,
    // rx_data, frame_err and parity_err do not change.
    always_comb begin
        armed_d      = armed_q | (sync_fill_q[1] & rxs);
        tick_cnt_d   = tick ? '0 : tick_cnt_q + 1'b1;
        state_d      = state_q;
        sc_d         = sc_q;
        bit_d        = bit_q;
        s1_d         = s1_q;
        s2_d         = s2_q;
        shreg_d      = shreg_q;
        pend_fe_d    = pend_fe_q;
        pend_pe_d    = pend_pe_q;
        all_zero_d   = all_zero_q;
        rx_data_d    = rx_data_q;
        rx_valid_d   = rx_valid_q;
        frame_err_d  = frame_err_q;
        parity_err_d = parity_err_q;
        overrun_d    = 1'b0;
        break_d      = 1'b0;
        complete     = 1'b0;

        maj      = (s1_q & s2_q) | (s1_q & rxs) | (s2_q & rxs);
        at_dec   = tick && (sc_q == SC_DEC);
        at_end   = tick && (sc_q == SC_LAST);
        par_req  = (PARITY == 2) ? ~(^shreg_q) : ^shreg_q;
        fe_now   = pend_fe_q | ~maj;
        zero_now = all_zero_q & ~maj;

        if (tick && state_q != S_IDLE) begin
            sc_d = (sc_q == SC_LAST) ? '0 : sc_q + 1'b1;
            if (sc_q == SC_S1) s1_d = rxs;
            if (sc_q == SC_S2) s2_d = rxs;
        end

        case (state_q)
            S_IDLE: begin
                if (armed_q && !rxs) begin
                    // Restart the divider so bit timing locks to this edge.
                    tick_cnt_d = '0;
                    sc_d       = '0;
                    bit_d      = '0;
                    pend_fe_d  = 1'b0;
                    pend_pe_d  = 1'b0;
                    all_zero_d = 1'b1;
                    state_d    = S_START;
                end
            end
            S_START: begin
                if (at_dec && maj) begin
                    state_d = S_IDLE;
                end else if (at_end) begin
                    bit_d   = '0;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (at_dec) begin
                    shreg_d    = {maj, shreg_q[DATA_BITS-1:1]};
                    all_zero_d = zero_now;
                end
                if (at_end) begin
                    if (bit_q == DB_LAST) begin
                        bit_d   = '0;
                        state_d = (PARITY != 0) ? S_PAR : S_STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            S_PAR: begin
                if (at_dec) begin
                    pend_pe_d  = (maj != par_req);
                    all_zero_d = zero_now;
                end
                if (at_end) begin
                    bit_d   = '0;
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (at_dec) begin
                    pend_fe_d  = fe_now;
                    all_zero_d = zero_now;
                    if (bit_q == SB_LAST) begin
                        // Finish at the decision point so the next start edge
                        // of a back-to-back frame is not missed.
                        complete = 1'b1;
                        state_d  = S_IDLE;
                    end
                end else if (at_end) begin
                    bit_d = bit_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;

        if (complete) begin
            if (zero_now) begin
                break_d = 1'b1;
            end else if (rx_valid_q && !rx_ready) begin
                overrun_d = 1'b1;
            end else begin
                rx_data_d    = shreg_q;
                frame_err_d  = fe_now;
                parity_err_d = pend_pe_q;
                rx_valid_d   = 1'b1;
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed_q      <= 1'b0;
            tick_cnt_q   <= '0;
            state_q      <= S_IDLE;
            sc_q         <= '0;
            bit_q        <= '0;
            s1_q         <= 1'b1;
            s2_q         <= 1'b1;
            shreg_q      <= '0;
            pend_fe_q    <= 1'b0;
            pend_pe_q    <= 1'b0;
            all_zero_q   <= 1'b0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            overrun_q    <= 1'b0;
            break_q      <= 1'b0;
        end else begin
            armed_q      <= armed_d;
            tick_cnt_q   <= tick_cnt_d;
            state_q      <= state_d;
            sc_q         <= sc_d;
            bit_q        <= bit_d;
            s1_q         <= s1_d;
            s2_q         <= s2_d;
            shreg_q      <= shreg_d;
            pend_fe_q    <= pend_fe_d;
            pend_pe_q    <= pend_pe_d;
            all_zero_q   <= all_zero_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
            overrun_q    <= overrun_d;
            break_q      <= break_d;
        end
    end

    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign frame_err  = frame_err_q;
    assign parity_err = parity_err_q;
    assign overrun    = overrun_q;
    assign break_det  = break_q;
    assign busy       = (state_q != S_IDLE);
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_uart_rx_os.sv
// Testbench for uart_rx_os. Two instances share the clock and reset: one is
// 8N1 and one is 8E2. Each instance has its own serial line and ready input.
// Bit period is 4 * 16 = 64 clocks.
`timescale 1ns/1ps
module tb_uart_rx_os;

    localparam int CLK_FREQ = 6_400_000;
    localparam int BAUD     = 100_000;
    localparam int BIT      = 64;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       rxd_n = 1'b1, rx_ready_n = 1'b1;
    logic [7:0] rx_data_n;
    logic       rx_valid_n, frame_err_n, parity_err_n, overrun_n, break_n, busy_n;
    logic [2:0] dbg_state_n;

    logic       rxd_e = 1'b1, rx_ready_e = 1'b1;
    logic [7:0] rx_data_e;
    logic       rx_valid_e, frame_err_e, parity_err_e, overrun_e, break_e, busy_e;
    logic [2:0] dbg_state_e;

    int checks = 0;
    int errors = 0;

    logic [9:0] got_n_q[$];
    logic [9:0] got_e_q[$];
    logic [9:0] exp_q[$];
    int rd_n = 0, rd_e = 0;
    int vcyc_n = 0, ovr_n = 0, brk_n = 0, busy_cyc_n = 0;
    int ovr_e = 0, brk_e = 0;

    uart_rx_os #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .OVERSAMPLE(16),
                 .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_dut_n (
        .clk(clk), .rst_n(rst_n), .rxd(rxd_n),
        .rx_data(rx_data_n), .rx_valid(rx_valid_n), .rx_ready(rx_ready_n),
        .frame_err(frame_err_n), .parity_err(parity_err_n), .overrun(overrun_n),
        .break_det(break_n), .busy(busy_n), .dbg_state(dbg_state_n)
    );

    uart_rx_os #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .OVERSAMPLE(16),
                 .DATA_BITS(8), .PARITY(1), .STOP_BITS(2)) u_dut_e (
        .clk(clk), .rst_n(rst_n), .rxd(rxd_e),
        .rx_data(rx_data_e), .rx_valid(rx_valid_e), .rx_ready(rx_ready_e),
        .frame_err(frame_err_e), .parity_err(parity_err_e), .overrun(overrun_e),
        .break_det(break_e), .busy(busy_e), .dbg_state(dbg_state_e)
    );

    // Clock and monitors: outputs are sampled on the falling edge.
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n) begin
            if (rx_valid_n) vcyc_n <= vcyc_n + 1;
            if (rx_valid_n && rx_ready_n) got_n_q.push_back({parity_err_n, frame_err_n, rx_data_n});
            if (overrun_n) ovr_n <= ovr_n + 1;
            if (break_n) brk_n <= brk_n + 1;
            if (busy_n) busy_cyc_n <= busy_cyc_n + 1;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (rx_valid_e && rx_ready_e) got_e_q.push_back({parity_err_e, frame_err_e, rx_data_e});
            if (overrun_e) ovr_e <= ovr_e + 1;
            if (break_e) brk_e <= brk_e + 1;
        end
    end

    // Reference model: outcome of one frame as {is_break, parity_err, frame_err, data}.
    // For the 8E2 instance the parity bit and both stop bits take part.
    function automatic logic [10:0] ref_outcome(input bit is_e, input logic [7:0] d,
                                                input logic par_bit, input logic [1:0] stops);
        logic fe, pe, brk;
        fe  = (stops[0] == 1'b0) || (is_e && stops[1] == 1'b0);
        pe  = is_e && (par_bit != (^d));
        brk = (d == 8'h00) && (!is_e || par_bit == 1'b0) &&
              (stops[0] == 1'b0) && (!is_e || stops[1] == 1'b0);
        return {brk, pe, fe, d};
    endfunction

    // Driver: hold a line level for a number of clocks, starting just after a rising edge.
    task automatic drive_line(input bit is_e, input logic v, input int cycles);
        if (is_e) rxd_e = v; else rxd_n = v;
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input bit is_e, input logic [7:0] d, input logic par_bit,
                              input logic [1:0] stops);
        drive_line(is_e, 1'b0, BIT);
        for (int i = 0; i < 8; i++) drive_line(is_e, d[i], BIT);
        if (is_e) drive_line(is_e, par_bit, BIT);
        drive_line(is_e, stops[0], BIT);
        if (is_e) drive_line(is_e, stops[1], BIT);
        if ((is_e ? stops[1] : stops[0]) == 1'b0) drive_line(is_e, 1'b1, 2 * BIT);
    endtask

    task automatic test_reset();
        checks++;
        if ({rx_data_n, rx_valid_n, frame_err_n, parity_err_n, overrun_n, break_n, busy_n} !== 14'd0) begin
            errors++;
            $display("FAIL reset_outputs_n: got %b required 0",
                     {rx_data_n, rx_valid_n, frame_err_n, parity_err_n, overrun_n, break_n, busy_n});
        end
        checks++;
        if ({rx_data_e, rx_valid_e, frame_err_e, parity_err_e, overrun_e, break_e, busy_e} !== 14'd0) begin
            errors++;
            $display("FAIL reset_outputs_e: got %b required 0",
                     {rx_data_e, rx_valid_e, frame_err_e, parity_err_e, overrun_e, break_e, busy_e});
        end
        checks++;
        if (dbg_state_n !== 3'd0 || dbg_state_e !== 3'd0) begin
            errors++;
            $display("FAIL reset_state: got %0d/%0d required 0/0", dbg_state_n, dbg_state_e);
        end
    endtask

    task automatic test_basic();
        int v0;
        v0 = vcyc_n;
        send_frame(1'b0, 8'hA5, 1'b1, 2'b11);
        drive_line(1'b0, 1'b1, BIT);
        checks++;
        if (got_n_q.size() - rd_n !== 1) begin
            errors++;
            $display("FAIL basic_count: got %0d words required 1", got_n_q.size() - rd_n);
        end else begin
            checks++;
            if (got_n_q[rd_n] !== {2'b00, 8'hA5}) begin
                errors++;
                $display("FAIL basic_word: got %h required %h", got_n_q[rd_n], {2'b00, 8'hA5});
            end
        end
        rd_n = got_n_q.size();
        checks++;
        if (vcyc_n - v0 !== 1) begin
            errors++;
            $display("FAIL basic_valid_cycles: got %0d required 1", vcyc_n - v0);
        end
    endtask

    task automatic test_back_to_back();
        logic [10:0] o;
        logic [7:0]  d;
        logic [1:0]  st;
        int nbrk, b0;
        exp_q.delete();
        nbrk = 0;
        b0   = brk_n;
        for (int i = 0; i < 12; i++) begin
            d  = 8'($urandom_range(0, 255));
            if (i == 5) d = 8'h00;
            st = {1'b1, 1'($urandom_range(0, 3) != 0)};
            o  = ref_outcome(1'b0, d, 1'b1, st);
            if (o[10]) nbrk++; else exp_q.push_back(o[9:0]);
            send_frame(1'b0, d, 1'b1, st);
        end
        drive_line(1'b0, 1'b1, BIT);
        checks++;
        if (got_n_q.size() - rd_n !== exp_q.size()) begin
            errors++;
            $display("FAIL b2b_count: got %0d words required %0d", got_n_q.size() - rd_n, exp_q.size());
        end
        foreach (exp_q[i]) begin
            if (rd_n + i < got_n_q.size()) begin
                checks++;
                if (got_n_q[rd_n + i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL b2b_word[%0d]: got %h required %h", i, got_n_q[rd_n + i], exp_q[i]);
                end
            end
        end
        rd_n = got_n_q.size();
        checks++;
        if (brk_n - b0 !== nbrk) begin
            errors++;
            $display("FAIL b2b_break: got %0d required %0d", brk_n - b0, nbrk);
        end
    endtask

    task automatic test_parity();
        logic [10:0] o;
        logic [7:0]  d;
        logic        p;
        logic [1:0]  st;
        int nbrk, b0;
        exp_q.delete();
        nbrk = 0;
        b0   = brk_e;
        for (int i = 0; i < 10; i++) begin
            case (i)
                0: begin d = 8'h37; p = 1'b1; st = 2'b11; end
                1: begin d = 8'h37; p = 1'b0; st = 2'b11; end
                2: begin d = 8'h96; p = 1'b0; st = 2'b01; end
                3: begin d = 8'h81; p = 1'b1; st = 2'b10; end
                4: begin d = 8'h00; p = 1'b0; st = 2'b00; end
                default: begin
                    d  = 8'($urandom_range(1, 255));
                    p  = 1'($urandom_range(0, 1));
                    st = 2'b11;
                end
            endcase
            o = ref_outcome(1'b1, d, p, st);
            if (o[10]) nbrk++; else exp_q.push_back(o[9:0]);
            send_frame(1'b1, d, p, st);
        end
        drive_line(1'b1, 1'b1, BIT);
        checks++;
        if (got_e_q.size() - rd_e !== exp_q.size()) begin
            errors++;
            $display("FAIL parity_count: got %0d words required %0d", got_e_q.size() - rd_e, exp_q.size());
        end
        foreach (exp_q[i]) begin
            if (rd_e + i < got_e_q.size()) begin
                checks++;
                if (got_e_q[rd_e + i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL parity_word[%0d]: got %h required %h", i, got_e_q[rd_e + i], exp_q[i]);
                end
            end
        end
        rd_e = got_e_q.size();
        checks++;
        if (brk_e - b0 !== nbrk) begin
            errors++;
            $display("FAIL parity_break: got %0d required %0d", brk_e - b0, nbrk);
        end
    endtask

    task automatic test_frame_break();
        int b0;
        b0 = brk_n;
        send_frame(1'b0, 8'h5A, 1'b1, 2'b00);
        checks++;
        if (got_n_q.size() - rd_n !== 1) begin
            errors++;
            $display("FAIL frame_err_count: got %0d words required 1", got_n_q.size() - rd_n);
        end else begin
            checks++;
            if (got_n_q[rd_n] !== {2'b01, 8'h5A}) begin
                errors++;
                $display("FAIL frame_err_word: got %h required %h", got_n_q[rd_n], {2'b01, 8'h5A});
            end
        end
        rd_n = got_n_q.size();
        // Ten bit times low, then two high.
        send_frame(1'b0, 8'h00, 1'b1, 2'b00);
        checks++;
        if (brk_n - b0 !== 1) begin
            errors++;
            $display("FAIL break_pulse: got %0d required 1", brk_n - b0);
        end
        checks++;
        if (got_n_q.size() - rd_n !== 0 || rx_valid_n !== 1'b0) begin
            errors++;
            $display("FAIL break_no_word: got %0d words valid=%b required 0 words valid=0",
                     got_n_q.size() - rd_n, rx_valid_n);
        end
        rd_n = got_n_q.size();
    endtask

    task automatic test_false_start();
        int b0, k0, w0;
        b0 = busy_cyc_n;
        k0 = brk_n;
        w0 = got_n_q.size();
        drive_line(1'b0, 1'b0, 20);
        drive_line(1'b0, 1'b1, BIT);
        checks++;
        if (busy_cyc_n - b0 <= 0) begin
            errors++;
            $display("FAIL glitch_busy_seen: got %0d busy cycles required >0", busy_cyc_n - b0);
        end
        checks++;
        if (busy_n !== 1'b0 || dbg_state_n !== 3'd0) begin
            errors++;
            $display("FAIL glitch_idle: got busy=%b state=%0d required busy=0 state=0", busy_n, dbg_state_n);
        end
        checks++;
        if (got_n_q.size() !== w0 || brk_n !== k0 || rx_valid_n !== 1'b0) begin
            errors++;
            $display("FAIL glitch_no_output: got words=%0d breaks=%0d required words=%0d breaks=%0d",
                     got_n_q.size(), brk_n, w0, k0);
        end
    endtask

    task automatic test_overrun();
        int o0;
        o0 = ovr_n;
        rx_ready_n = 1'b0;
        send_frame(1'b0, 8'h11, 1'b1, 2'b11);
        send_frame(1'b0, 8'h22, 1'b1, 2'b11);
        drive_line(1'b0, 1'b1, BIT);
        checks++;
        if (rx_valid_n !== 1'b1 || rx_data_n !== 8'h11 || frame_err_n !== 1'b0) begin
            errors++;
            $display("FAIL overrun_held: got valid=%b data=%h fe=%b required valid=1 data=11 fe=0",
                     rx_valid_n, rx_data_n, frame_err_n);
        end
        checks++;
        if (ovr_n - o0 !== 1) begin
            errors++;
            $display("FAIL overrun_pulse: got %0d required 1", ovr_n - o0);
        end
        rx_ready_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (rx_valid_n !== 1'b0) begin
            errors++;
            $display("FAIL overrun_release: got valid=%b required 0", rx_valid_n);
        end
        checks++;
        if (got_n_q.size() - rd_n !== 1 || got_n_q[got_n_q.size() - 1] !== {2'b00, 8'h11}) begin
            errors++;
            $display("FAIL overrun_transfer: got %0d words required one word 011", got_n_q.size() - rd_n);
        end
        rd_n = got_n_q.size();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_midframe();
        logic [7:0] d;
        int b0;
        d = 8'hC3;
        drive_line(1'b0, 1'b0, BIT);
        for (int i = 0; i < 4; i++) drive_line(1'b0, d[i], BIT);
        drive_line(1'b0, d[4], BIT / 2);
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy_n !== 1'b0 || rx_valid_n !== 1'b0) begin
            errors++;
            $display("FAIL midframe_reset_async: got busy=%b valid=%b required 0/0", busy_n, rx_valid_n);
        end
        drive_line(1'b0, 1'b0, 5);
        rst_n = 1'b1;
        b0 = busy_cyc_n;
        drive_line(1'b0, 1'b0, 3 * BIT);
        checks++;
        if (busy_cyc_n - b0 !== 0) begin
            errors++;
            $display("FAIL stuck_low_no_start: got %0d busy cycles required 0", busy_cyc_n - b0);
        end
        drive_line(1'b0, 1'b1, 2 * BIT);
        send_frame(1'b0, 8'h3C, 1'b1, 2'b11);
        drive_line(1'b0, 1'b1, BIT);
        checks++;
        if (got_n_q.size() - rd_n !== 1) begin
            errors++;
            $display("FAIL midframe_count: got %0d words required 1", got_n_q.size() - rd_n);
        end else begin
            checks++;
            if (got_n_q[rd_n] !== {2'b00, 8'h3C}) begin
                errors++;
                $display("FAIL midframe_word: got %h required %h", got_n_q[rd_n], {2'b00, 8'h3C});
            end
        end
        rd_n = got_n_q.size();
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b1;
        test_reset();
        drive_line(1'b0, 1'b1, 8);
        test_basic();
        test_parity();
        test_frame_break();
        test_false_start();
        test_overrun();
        test_back_to_back();
        test_reset_midframe();
        checks++;
        if (ovr_e !== 0) begin
            errors++;
            $display("FAIL overrun_spurious_e: got %0d required 0", ovr_e);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
